// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int beat_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first set request at or above ptr_i,
// wrapping circularly through NUM_REQ entries.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               any_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0]      pos [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // Candidate position for each offset; wrap by compare so odd NUM_REQ works.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_off
    logic [IW:0] sum;
    assign sum     = {1'b0, ptr_i} + (IW+1)'(gi);
    assign pos[gi] = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ))
                                               : sum[IW-1:0];
    assign hit[gi] = req_i[pos[gi]];
  end

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) idx_o = pos[k];
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers,
// holding the grant for a burst ending on last beat or MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [WIDTH-1:0]            fifo_w_data,
  output logic                        fifo_w_en,
  input  logic                        fifo_full,
  output logic [grant_w(NUM_REQ)-1:0] grant_id,
  output logic                        busy
);

  localparam int IW = grant_w(NUM_REQ);
  localparam int CW = beat_cnt_w(MAX_BURST);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e      state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_d;
  logic [IW-1:0]   grant_id_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            busy_q;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic            xfer;
  logic            burst_end;
  logic [WIDTH-1:0] data_arr [NUM_REQ];

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Handshake outputs are combinational so a full FIFO stalls in the same cycle.
  always_comb begin
    req_ready   = '0;
    fifo_w_en   = 1'b0;
    fifo_w_data = '0;
    if (!rst && state_q == BURST) begin
      req_ready[grant_id_q] = !fifo_full;
      fifo_w_en             = req_valid[grant_id_q] && !fifo_full;
      fifo_w_data           = data_arr[grant_id_q];
    end
  end

  assign xfer      = fifo_w_en;
  assign burst_end = xfer && (req_last[grant_id_q] || beat_cnt_q == LAST_BEAT);
  assign rr_ptr_d  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_id_q <= pick_idx;
            beat_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= '0;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the write port of one synchronous FIFO (syn_fifo style: w_data/w_en/full) between NUM_REQ producers.
- Grants one producer at a time and locks the grant for a burst, so a producer's beats land contiguously in the FIFO.
- Releases the grant on the producer's last beat or after MAX_BURST beats, whichever comes first.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width; equals FIFO WIDTH
MAX_BURST, 4, max beats per grant (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*WIDTH  per-requester data; requester i at bits [i*WIDTH +: WIDTH]
req_last  in  NUM_REQ  per-requester last beat of packet
req_ready  out  NUM_REQ  per-requester accept
fifo_w_data  out  WIDTH  to FIFO w_data
fifo_w_en  out  1  to FIFO w_en
fifo_full  in  1  from FIFO full
grant_id  out  $clog2(NUM_REQ)  current/last granted requester
busy  out  1  high while in BURST

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0, req_ready=0, fifo_w_en=0, fifo_w_data=0.
- rst gating: while rst=1, req_ready and fifo_w_en are forced 0 combinationally.
- IDLE state:
  - req_ready=0 and fifo_w_en=0.
  - If any req_valid is set, pick the first set bit searching circularly from rr_ptr upward.
  - Next edge: grant_id<=pick, beat_cnt<=0, state<=BURST.
  - Arbitration latency is 1 cycle; no data moves in IDLE.
- BURST state, with g=grant_id:
  - req_ready[g] = !fifo_full; all other req_ready are 0.
  - fifo_w_en = req_valid[g] && !fifo_full.
  - fifo_w_data = req_data[g] (combinational mux, valid regardless of w_en).
  - A beat transfers when req_valid[g] && req_ready[g]; on a transfer, beat_cnt increments.
- Burst end:
  - Condition: transfer with req_last[g]=1, or transfer with beat_cnt==MAX_BURST-1.
  - Next edge: state<=IDLE, rr_ptr<=(g+1) mod NUM_REQ, beat_cnt<=0.
  - This leaves exactly one idle cycle between bursts.
- Full FIFO: no transfer occurs, beat_cnt holds, and the grant is kept. fifo_w_en is never asserted while fifo_full=1.
- Granted requester drops req_valid mid-burst: the grant is held (no timeout) and no beats are counted.
- Requester deasserting valid in IDLE after being picked: the grant still takes effect, and the block waits in BURST.
- grant_id holds its last value in IDLE.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr wraps to 0 after NUM_REQ-1; for non-power-of-2 NUM_REQ, wrap is an explicit compare, not a bit truncation.
- Reset mid-burst: outputs gate to 0 in the same cycle; next cycle the block is in IDLE with rr_ptr=0. A partially written packet is not rolled back.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_e enum {IDLE, BURST}.
  - Functions for the grant-id and beat-count width ($clog2 helpers).
- Sub-module rr_pick:
  - Combinational rotating-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, index.
  - Instantiated once.

Test Plan:
All tests use NUM_REQ=4, WIDTH=8, MAX_BURST=4.
1. Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0000, fifo_w_en=0, grant_id=0, busy=0; first grant comes 1 cycle after rst falls.
2. Single packet: only requester 1 sends 0x11, 0x22, 0x33 (last on 0x33) -> grant_id=1, busy=1 the cycle after valid; FIFO receives 0x11, 0x22, 0x33 on 3 consecutive cycles; IDLE next; rr_ptr=2.
3. Fairness: all 4 requesters valid continuously, req_last=0 -> grants 0,1,2,3,0 in order, each exactly 4 writes, 1 bubble between.
4. Backpressure: fifo_full=1 for 3 cycles after beat 2 of requester 0 -> req_ready[0]=0 and fifo_w_en=0 for those 3 cycles; beats 3-4 are written after full drops; total 4 writes.
5. Rotation skip: rr_ptr=1, only requesters 0 and 3 valid -> requester 3 granted first, then requester 0.
6. Reset mid-burst: rst=1 during beat 2 of requester 2 -> fifo_w_en=0 that cycle; next cycle busy=0, grant_id=0, and rr_ptr=0, so requester 0 wins the next arbitration if valid.
